// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32IM core: latches decoded instructions, resolves
// EX/MEM and MEM/WB forwarding, and handles load-use bubbles, flushes and downstream stalls.
module id_ex_stage (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        id_valid,
   input  logic [31:0] id_pc,
   input  logic [4:0]  id_rs1_addr,
   input  logic [4:0]  id_rs2_addr,
   input  logic [4:0]  id_rd_addr,
   input  logic [31:0] id_rs1_data,
   input  logic [31:0] id_rs2_data,
   input  logic [31:0] id_imm,
   input  logic        id_use_imm,
   input  logic [6:0]  id_func7,
   input  logic [2:0]  id_func3,
   input  logic        id_reg_write,
   input  logic        id_mem_read,
   input  logic        id_mem_write,
   input  logic        flush,
   input  logic        ex_stall,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_data,
   output logic        id_ready,
   output logic        ex_valid,
   output logic [31:0] ex_pc,
   output logic [31:0] ex_op_a,
   output logic [31:0] ex_op_b,
   output logic [31:0] ex_store_data,
   output logic [6:0]  ex_func7,
   output logic [2:0]  ex_func3,
   output logic [4:0]  ex_rd,
   output logic        ex_reg_write,
   output logic        ex_mem_read,
   output logic        ex_mem_write
);

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [4:0]  rd;
      logic [31:0] rs1_data;
      logic [31:0] rs2_data;
      logic [31:0] imm;
      logic        use_imm;
      logic [6:0]  func7;
      logic [2:0]  func3;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
   } ex_t;

   ex_t         id_p0;
   ex_t         ex_p1;
   logic        vld_p1;
   logic        load_use;
   logic [31:0] fwd_rs1;
   logic [31:0] fwd_rs2;

   // EX/MEM beats MEM/WB; x0 is never forwarded.
   function automatic logic [31:0] fwd_sel(
      input logic [4:0]  src,
      input logic [31:0] stored,
      input logic        xw,
      input logic [4:0]  xrd,
      input logic [31:0] xres,
      input logic        ww,
      input logic [4:0]  wrd,
      input logic [31:0] wdat
   );
      if (xw && (xrd == src) && (src != 5'd0))
         return xres;
      else if (ww && (wrd == src) && (src != 5'd0))
         return wdat;
      else
         return stored;
   endfunction

   // Immediate forms never carry M-extension bits; only SRAI keeps func7[5].
   function automatic logic [6:0] shape_func7(
      input logic       use_imm,
      input logic [2:0] f3,
      input logic [6:0] f7
   );
      if (!use_imm)
         return f7;
      else if (f3 == 3'd5)
         return {1'b0, f7[5], 5'b0};
      else
         return 7'd0;
   endfunction

   // ---- stage p0: decode-side capture and hazard detection ----
   always_comb begin
      id_p0           = '0;
      id_p0.pc        = id_pc;
      id_p0.rs1_addr  = id_rs1_addr;
      id_p0.rs2_addr  = id_rs2_addr;
      id_p0.rd        = id_rd_addr;
      id_p0.rs1_data  = id_rs1_data;
      id_p0.rs2_data  = id_rs2_data;
      id_p0.imm       = id_imm;
      id_p0.use_imm   = id_use_imm;
      id_p0.func7     = shape_func7(id_use_imm, id_func3, id_func7);
      id_p0.func3     = id_func3;
      id_p0.reg_write = id_valid & id_reg_write & (id_rd_addr != 5'd0);
      id_p0.mem_read  = id_valid & id_mem_read;
      id_p0.mem_write = id_valid & id_mem_write;
   end

   assign load_use = vld_p1 & ex_p1.mem_read & (ex_p1.rd != 5'd0) & id_valid &
                     ((id_rs1_addr == ex_p1.rd) |
                      ((id_rs2_addr == ex_p1.rd) & (!id_use_imm | id_mem_write)));

   assign id_ready = !ex_stall & !load_use;

   // ---- stage p1: EX register ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         ex_p1  <= '0;
      end else if (flush || (!ex_stall && load_use)) begin
         vld_p1 <= 1'b0;
         ex_p1  <= '0;
      end else if (ex_stall) begin
         // Refresh so a producer leaving MEM/WB during the hold is not lost.
         ex_p1.rs1_data <= fwd_rs1;
         ex_p1.rs2_data <= fwd_rs2;
      end else begin
         vld_p1 <= id_valid;
         ex_p1  <= id_p0;
      end
   end

   assign fwd_rs1 = fwd_sel(ex_p1.rs1_addr, ex_p1.rs1_data, exmem_reg_write, exmem_rd,
                            exmem_result, memwb_reg_write, memwb_rd, memwb_data);
   assign fwd_rs2 = fwd_sel(ex_p1.rs2_addr, ex_p1.rs2_data, exmem_reg_write, exmem_rd,
                            exmem_result, memwb_reg_write, memwb_rd, memwb_data);

   assign ex_valid      = vld_p1;
   assign ex_pc         = ex_p1.pc;
   assign ex_op_a       = fwd_rs1;
   assign ex_op_b       = ex_p1.use_imm ? ex_p1.imm : fwd_rs2;
   assign ex_store_data = fwd_rs2;
   assign ex_func7      = ex_p1.func7;
   assign ex_func3      = ex_p1.func3;
   assign ex_rd         = ex_p1.rd;
   assign ex_reg_write  = ex_p1.reg_write;
   assign ex_mem_read   = ex_p1.mem_read;
   assign ex_mem_write  = ex_p1.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a table of single-cycle vectors plus hand-written
// sequences for load-use, stall refresh, flush and asynchronous reset.
module tb_id_ex_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid;
   logic [31:0] id_pc;
   logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
   logic [31:0] id_rs1_data, id_rs2_data, id_imm;
   logic        id_use_imm;
   logic [6:0]  id_func7;
   logic [2:0]  id_func3;
   logic        id_reg_write, id_mem_read, id_mem_write;
   logic        flush, ex_stall;
   logic        exmem_reg_write;
   logic [4:0]  exmem_rd;
   logic [31:0] exmem_result;
   logic        memwb_reg_write;
   logic [4:0]  memwb_rd;
   logic [31:0] memwb_data;
   logic        id_ready, ex_valid;
   logic [31:0] ex_pc, ex_op_a, ex_op_b, ex_store_data;
   logic [6:0]  ex_func7;
   logic [2:0]  ex_func3;
   logic [4:0]  ex_rd;
   logic        ex_reg_write, ex_mem_read, ex_mem_write;

   int pass_cnt = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
      .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
      .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
      .id_use_imm(id_use_imm), .id_func7(id_func7), .id_func3(id_func3),
      .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
      .flush(flush), .ex_stall(ex_stall),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
      .id_ready(id_ready), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_op_a(ex_op_a),
      .ex_op_b(ex_op_b), .ex_store_data(ex_store_data), .ex_func7(ex_func7),
      .ex_func3(ex_func3), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write)
   );

   typedef struct {
      logic        valid;
      logic [4:0]  rs1, rs2, rd;
      logic [31:0] rs1d, rs2d, imm;
      logic        use_imm;
      logic [6:0]  f7;
      logic [2:0]  f3;
      logic        rw, mw;
      logic        xw;
      logic [4:0]  xrd;
      logic [31:0] xres;
      logic        ww;
      logic [4:0]  wrd;
      logic [31:0] wdat;
      logic [31:0] e_opa, e_opb, e_st;
      logic [6:0]  e_f7;
      logic [2:0]  e_f3;
      logic [4:0]  e_rd;
      logic        e_rw, e_vld;
   } vec_t;

   vec_t vecs[12];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   task automatic idle();
      id_valid = 1'b0; id_pc = 32'd0;
      id_rs1_addr = 5'd0; id_rs2_addr = 5'd0; id_rd_addr = 5'd0;
      id_rs1_data = 32'd0; id_rs2_data = 32'd0; id_imm = 32'd0;
      id_use_imm = 1'b0; id_func7 = 7'd0; id_func3 = 3'd0;
      id_reg_write = 1'b0; id_mem_read = 1'b0; id_mem_write = 1'b0;
      flush = 1'b0; ex_stall = 1'b0;
      exmem_reg_write = 1'b0; exmem_rd = 5'd0; exmem_result = 32'd0;
      memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
   endtask

   task automatic apply(input vec_t v, input logic [31:0] pc);
      id_valid = v.valid; id_pc = pc;
      id_rs1_addr = v.rs1; id_rs2_addr = v.rs2; id_rd_addr = v.rd;
      id_rs1_data = v.rs1d; id_rs2_data = v.rs2d; id_imm = v.imm;
      id_use_imm = v.use_imm; id_func7 = v.f7; id_func3 = v.f3;
      id_reg_write = v.rw; id_mem_read = 1'b0; id_mem_write = v.mw;
      exmem_reg_write = v.xw; exmem_rd = v.xrd; exmem_result = v.xres;
      memwb_reg_write = v.ww; memwb_rd = v.wrd; memwb_data = v.wdat;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      //        vld  rs1   rs2   rd     rs1d           rs2d        imm        ui    f7     f3    rw    mw    xw    xrd   xres           ww    wrd   wdat           opa            opb            st            ef7    ef3   erd    erw   evld
      vecs[0]  = '{1'b1, 5'd1, 5'd0, 5'd2,  32'd5,         32'd0,      32'd7,     1'b1, 7'h20, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         32'd5,         32'd7,         32'd0,         7'h00, 3'd0, 5'd2,  1'b1, 1'b1};
      vecs[1]  = '{1'b1, 5'd1, 5'd0, 5'd3,  32'h8000_0000, 32'd0,      32'h405,   1'b1, 7'h21, 3'd5, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         32'h8000_0000, 32'h405,       32'd0,         7'h20, 3'd5, 5'd3,  1'b1, 1'b1};
      vecs[2]  = '{1'b1, 5'd1, 5'd2, 5'd4,  32'd10,        32'd20,     32'd0,     1'b0, 7'h21, 3'd5, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         32'd10,        32'd20,        32'd20,        7'h21, 3'd5, 5'd4,  1'b1, 1'b1};
      vecs[3]  = '{1'b1, 5'd1, 5'd2, 5'd5,  32'd6,         32'd7,      32'd0,     1'b0, 7'h01, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         32'd6,         32'd7,         32'd7,         7'h01, 3'd0, 5'd5,  1'b1, 1'b1};
      vecs[4]  = '{1'b1, 5'd1, 5'd0, 5'd6,  32'd3,         32'd0,      32'd1,     1'b1, 7'h21, 3'd1, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         32'd3,         32'd1,         32'd0,         7'h00, 3'd1, 5'd6,  1'b1, 1'b1};
      vecs[5]  = '{1'b1, 5'd1, 5'd2, 5'd0,  32'd1,         32'd2,      32'd0,     1'b0, 7'h00, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         32'd1,         32'd2,         32'd2,         7'h00, 3'd0, 5'd0,  1'b0, 1'b1};
      vecs[6]  = '{1'b0, 5'd0, 5'd0, 5'd7,  32'd0,         32'd0,      32'd0,     1'b0, 7'h00, 3'd0, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0,         1'b0, 5'd0, 32'd0,         32'd0,         32'd0,         32'd0,         7'h00, 3'd0, 5'd7,  1'b0, 1'b0};
      vecs[7]  = '{1'b1, 5'd3, 5'd0, 5'd8,  32'd1,         32'd0,      32'd5,     1'b1, 7'h00, 3'd0, 1'b1, 1'b0, 1'b1, 5'd3, 32'hAA,        1'b1, 5'd3, 32'hBB,        32'hAA,        32'd5,         32'd0,         7'h00, 3'd0, 5'd8,  1'b1, 1'b1};
      vecs[8]  = '{1'b1, 5'd1, 5'd4, 5'd9,  32'd2,         32'd9,      32'd0,     1'b0, 7'h00, 3'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0,         1'b1, 5'd4, 32'h55,        32'd2,         32'h55,        32'h55,        7'h00, 3'd0, 5'd9,  1'b1, 1'b1};
      vecs[9]  = '{1'b1, 5'd1, 5'd6, 5'd0,  32'h200,       32'h77,     32'd8,     1'b1, 7'h00, 3'd2, 1'b0, 1'b1, 1'b1, 5'd6, 32'h99,        1'b0, 5'd0, 32'd0,         32'h200,       32'd8,         32'h99,        7'h00, 3'd2, 5'd0,  1'b0, 1'b1};
      vecs[10] = '{1'b1, 5'd0, 5'd0, 5'd11, 32'h11,        32'h22,     32'd0,     1'b0, 7'h00, 3'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'hAA,        1'b1, 5'd0, 32'hBB,        32'h11,        32'h22,        32'h22,        7'h00, 3'd0, 5'd11, 1'b1, 1'b1};
      vecs[11] = '{1'b1, 5'd12, 5'd13, 5'd14, 32'd1,       32'd2,      32'd0,     1'b0, 7'h20, 3'd0, 1'b1, 1'b0, 1'b1, 5'd13, 32'h1111,     1'b1, 5'd12, 32'h2222,     32'h2222,      32'h1111,      32'h1111,      7'h20, 3'd0, 5'd14, 1'b1, 1'b1};

      // Reset state
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst ex_valid", 32'(ex_valid), 32'd0);
      chk("rst ex_op_a", ex_op_a, 32'd0);
      chk("rst ex_reg_write", 32'(ex_reg_write), 32'd0);
      chk("rst id_ready", 32'(id_ready), 32'd1);
      rst_n = 1'b1;

      // Table-driven single-cycle vectors
      for (int i = 0; i < 12; i++) begin
         logic [31:0] pc;
         pc = 32'h1000 + 32'(i * 4);
         apply(vecs[i], pc);
         tick();
         chk($sformatf("v%0d op_a", i), ex_op_a, vecs[i].e_opa);
         chk($sformatf("v%0d op_b", i), ex_op_b, vecs[i].e_opb);
         chk($sformatf("v%0d store", i), ex_store_data, vecs[i].e_st);
         chk($sformatf("v%0d func7", i), 32'(ex_func7), 32'(vecs[i].e_f7));
         chk($sformatf("v%0d func3", i), 32'(ex_func3), 32'(vecs[i].e_f3));
         chk($sformatf("v%0d rd", i), 32'(ex_rd), 32'(vecs[i].e_rd));
         chk($sformatf("v%0d reg_write", i), 32'(ex_reg_write), 32'(vecs[i].e_rw));
         chk($sformatf("v%0d valid", i), 32'(ex_valid), 32'(vecs[i].e_vld));
         chk($sformatf("v%0d mem_write", i), 32'(ex_mem_write), 32'(vecs[i].mw & vecs[i].valid));
         chk($sformatf("v%0d pc", i), ex_pc, pc);
      end

      // Double forward: drop EX/MEM, then MEM/WB
      apply(vecs[7], 32'h2000);
      tick();
      exmem_reg_write = 1'b0;
      #1 chk("dfwd memwb", ex_op_a, 32'hBB);
      memwb_reg_write = 1'b0;
      #1 chk("dfwd stored", ex_op_a, 32'd1);

      // Load-use: LW x5 in EX, ADD x6,x1,x5 in ID
      idle();
      id_valid = 1'b1; id_rs1_addr = 5'd1; id_rd_addr = 5'd5; id_rs1_data = 32'h100;
      id_imm = 32'd4; id_use_imm = 1'b1; id_func3 = 3'd2; id_reg_write = 1'b1; id_mem_read = 1'b1;
      tick();
      chk("lu lw mem_read", 32'(ex_mem_read), 32'd1);
      idle();
      id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs2_addr = 5'd5; id_rd_addr = 5'd6;
      id_rs1_data = 32'd3; id_rs2_data = 32'd0; id_reg_write = 1'b1;
      #1 chk("lu id_ready low", 32'(id_ready), 32'd0);
      tick();
      chk("lu bubble valid", 32'(ex_valid), 32'd0);
      chk("lu id_ready back", 32'(id_ready), 32'd1);
      memwb_reg_write = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hCAFE;
      tick();
      chk("lu add valid", 32'(ex_valid), 32'd1);
      chk("lu add rd", 32'(ex_rd), 32'd6);
      chk("lu add op_a", ex_op_a, 32'd3);
      chk("lu add op_b fwd", ex_op_b, 32'hCAFE);

      // Load-use boundary: rs2 matches but is only an immediate slot unless storing
      idle();
      id_valid = 1'b1; id_rd_addr = 5'd5; id_reg_write = 1'b1; id_mem_read = 1'b1; id_use_imm = 1'b1;
      tick();
      idle();
      id_valid = 1'b1; id_rs1_addr = 5'd1; id_rs2_addr = 5'd5; id_use_imm = 1'b1; id_rd_addr = 5'd2;
      #1 chk("lu imm no hazard", 32'(id_ready), 32'd1);
      id_mem_write = 1'b1;
      #1 chk("lu store hazard", 32'(id_ready), 32'd0);
      id_valid = 1'b0;
      #1 chk("lu idle no hazard", 32'(id_ready), 32'd1);
      tick();

      // Stall refresh: ADD x8,x7 forwarding x7 from MEM/WB, held for 3 cycles
      idle();
      id_valid = 1'b1; id_rs1_addr = 5'd7; id_rd_addr = 5'd8; id_reg_write = 1'b1;
      memwb_reg_write = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h1234;
      tick();
      chk("st pre op_a", ex_op_a, 32'h1234);
      ex_stall = 1'b1;
      id_rs1_addr = 5'd1; id_rd_addr = 5'd10; id_rs1_data = 32'h42;
      tick();
      memwb_reg_write = 1'b0; memwb_rd = 5'd0; memwb_data = 32'd0;
      #1 chk("st c1 op_a", ex_op_a, 32'h1234);
      chk("st c1 rd", 32'(ex_rd), 32'd8);
      chk("st c1 id_ready", 32'(id_ready), 32'd0);
      tick();
      chk("st c2 op_a", ex_op_a, 32'h1234);
      chk("st c2 valid", 32'(ex_valid), 32'd1);
      tick();
      chk("st c3 op_a", ex_op_a, 32'h1234);
      chk("st c3 rd", 32'(ex_rd), 32'd8);
      ex_stall = 1'b0;
      #1 chk("st rel rd", 32'(ex_rd), 32'd8);
      tick();
      chk("st next rd", 32'(ex_rd), 32'd10);
      chk("st next op_a", ex_op_a, 32'h42);

      // Flush beats stall
      flush = 1'b1; ex_stall = 1'b1;
      tick();
      chk("fl valid", 32'(ex_valid), 32'd0);
      chk("fl reg_write", 32'(ex_reg_write), 32'd0);
      flush = 1'b0; ex_stall = 1'b0;

      // Asynchronous reset mid-stall
      apply(vecs[0], 32'h3000);
      tick();
      ex_stall = 1'b1;
      chk("ar pre valid", 32'(ex_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1 chk("ar valid", 32'(ex_valid), 32'd0);
      chk("ar op_a", ex_op_a, 32'd0);
      chk("ar op_b", ex_op_b, 32'd0);
      chk("ar pc", ex_pc, 32'd0);
      chk("ar rd", 32'(ex_rd), 32'd0);
      chk("ar reg_write", 32'(ex_reg_write), 32'd0);
      chk("ar id_ready stall", 32'(id_ready), 32'd0);
      ex_stall = 1'b0;
      #1 chk("ar id_ready", 32'(id_ready), 32'd1);
      rst_n = 1'b1;
      tick();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
